// File: rtl/step_input_conditioner.sv
// Front-panel button conditioner: synchronises and debounces the manual-step
// toggle and step buttons, then shapes them into clean pulses for the clock module.

module step_input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic i_SYS_CLOCK,
  input  logic i_RESET_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [31:0] LAST = 32'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync;
  logic [31:0] cnt;
  logic        expire;

  // The level flips on the edge where the disagreement run would reach DEBOUNCE_CYCLES.
  assign expire = (sync[1] != level) && (cnt == LAST);
  assign rise   = expire && !level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (expire) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

module step_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter bit          REPEAT_ENABLE   = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic i_SYS_CLOCK,
  input  logic i_RESET_n,
  input  logic i_BTN_TOGGLE,
  input  logic i_BTN_STEP,
  output logic o_STEP_TOGGLE,
  output logic o_STEP_CLOCK,
  output logic o_TOGGLE_LEVEL,
  output logic o_STEP_LEVEL
);

  localparam logic [31:0] PULSE_LAST  = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);
  localparam logic [31:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT
  } step_state_e;

  step_state_e state_q, state_d;
  logic [31:0] r_CNT, cnt_d;
  logic        r_FIRST, first_d;
  logic [31:0] wait_last;
  logic        tog_rise;
  logic        stp_rise;

  step_input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_toggle_db (
    .i_SYS_CLOCK (i_SYS_CLOCK),
    .i_RESET_n   (i_RESET_n),
    .raw         (i_BTN_TOGGLE),
    .level       (o_TOGGLE_LEVEL),
    .rise        (tog_rise)
  );

  step_input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .i_SYS_CLOCK (i_SYS_CLOCK),
    .i_RESET_n   (i_RESET_n),
    .raw         (i_BTN_STEP),
    .level       (o_STEP_LEVEL),
    .rise        (stp_rise)
  );

  // The first gap after a press is the long hold-off; later gaps are the repeat period.
  assign wait_last = r_FIRST ? DELAY_LAST : PERIOD_LAST;

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = r_CNT;
    first_d = r_FIRST;
    case (state_q)
      S_IDLE: begin
        if (stp_rise) begin
          state_d = S_PULSE;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      S_PULSE: begin
        if (r_CNT == PULSE_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = r_CNT + 32'd1;
        end
      end
      S_WAIT: begin
        // Release is honoured only after the minimum low time has elapsed.
        if (!o_STEP_LEVEL && (r_CNT >= PULSE_LAST)) begin
          state_d = S_IDLE;
        end else if (REPEAT_ENABLE && o_STEP_LEVEL && (r_CNT == wait_last)) begin
          state_d = S_PULSE;
          cnt_d   = '0;
          first_d = 1'b0;
        end else if (r_CNT != CNT_MAX) begin
          cnt_d = r_CNT + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q       <= S_IDLE;
      r_CNT         <= '0;
      r_FIRST       <= 1'b0;
      o_STEP_CLOCK  <= 1'b0;
      o_STEP_TOGGLE <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_CNT         <= cnt_d;
      r_FIRST       <= first_d;
      o_STEP_CLOCK  <= (state_d == S_PULSE);
      o_STEP_TOGGLE <= tog_rise;
    end
  end

endmodule

// File: doc/step_input_conditioner.md
Name: step_input_conditioner

Overview:
Conditions the two raw front-panel push-buttons (manual-step toggle and manual step) before they reach the clock module's i_STEP_TOGGLE and i_STEP_CLOCK inputs. Each button gets a 2-flop synchronizer and a counter-based debouncer. The toggle channel emits one clean single-cycle pulse per press. The step channel runs an FSM that emits a fixed-width step pulse per press, plus optional auto-repeat while the button is held.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive i_SYS_CLOCK cycles a synchronized input must differ from the debounced level before that level flips; legal range ≥1, ≥ PULSE_CYCLES.
PULSE_CYCLES, 4, high time of each o_STEP_CLOCK pulse; also the minimum low time after each pulse; ≥1.
REPEAT_ENABLE, 1, 1 = auto-repeat while the step button is held; 0 = exactly one pulse per press.
REPEAT_DELAY, 25000000, low cycles after the first pulse before the first repeat; > PULSE_CYCLES.
REPEAT_PERIOD, 5000000, low cycles between subsequent repeats; > PULSE_CYCLES.

Ports:
i_SYS_CLOCK  input  1  system clock; all state on rising edge
i_RESET_n  input  1  asynchronous active-low reset
i_BTN_TOGGLE  input  1  raw toggle button, active-high, asynchronous, bouncy
i_BTN_STEP  input  1  raw step button, active-high, asynchronous, bouncy
o_STEP_TOGGLE  output  1  one-cycle pulse per debounced toggle press; drives clock i_STEP_TOGGLE
o_STEP_CLOCK  output  1  step pulse train; drives clock i_STEP_CLOCK
o_TOGGLE_LEVEL  output  1  debounced toggle button level (status/LED)
o_STEP_LEVEL  output  1  debounced step button level (status/LED)

Behaviour:
- Reset (i_RESET_n=0, asynchronous): synchronizer flops, debounced levels, counters, and FSM cleared; FSM in IDLE. All outputs 0. Applies immediately even mid-pulse; o_STEP_CLOCK drops with no glitch-back on reset release.
- All outputs are registered; no combinational path from any input to any output.
- Synchronizer: two flops per button, reset 0.
- Debouncer (per channel): 32-bit counter.
  - Synchronized value equal to debounced level → counter cleared to 0.
  - Otherwise counter increments. On the cycle it would reach DEBOUNCE_CYCLES, the level flips and the counter clears.
  - Any single-cycle agreement before that restarts the count.
  - Latency from first synchronized-high sample to level rise: DEBOUNCE_CYCLES cycles.
  - Total latency from a clean raw edge: DEBOUNCE_CYCLES+2 edges.
- o_STEP_TOGGLE: high for exactly one cycle, registered on the same edge o_TOGGLE_LEVEL rises. No pulse on release.
- Step FSM, states IDLE, PULSE, WAIT; internal flag r_FIRST; 32-bit cycle counter r_CNT:
  - IDLE: o_STEP_CLOCK=0. On a debounced step rise (same edge o_STEP_LEVEL rises) → PULSE, r_CNT=0, r_FIRST=1.
  - PULSE: o_STEP_CLOCK=1. Stays PULSE_CYCLES cycles, then → WAIT, r_CNT=0.
  - WAIT: o_STEP_CLOCK=0. Let W = r_FIRST ? REPEAT_DELAY : REPEAT_PERIOD.
    - If o_STEP_LEVEL=0 and r_CNT ≥ PULSE_CYCLES-1 → IDLE. Minimum low time is always honoured, even if released mid-pulse.
    - Else if REPEAT_ENABLE=1, o_STEP_LEVEL=1 and r_CNT=W-1 → PULSE, r_CNT=0, r_FIRST=0.
    - Else r_CNT increments; saturates when REPEAT_ENABLE=0.
  - A debounced rise is acted on only in IDLE. Presses while in PULSE/WAIT do not queue.
  - Release during PULSE does not truncate the pulse.
- Channels are fully independent. Simultaneous presses yield both o_STEP_TOGGLE and the step pulse in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, REPEAT_DELAY=10, REPEAT_PERIOD=6, REPEAT_ENABLE=1 unless noted):
1. Reset: hold i_RESET_n=0 with both buttons high → all four outputs 0. Release reset with buttons still high → o_STEP_LEVEL rises 6 edges later; o_STEP_CLOCK high exactly 2 cycles.
2. Bounce reject: i_BTN_TOGGLE toggling every 2 cycles for 40 cycles, then steady high → exactly one o_STEP_TOGGLE pulse, 6 edges after steady high; none on release.
3. Single step: press i_BTN_STEP for 8 cycles then release → exactly one o_STEP_CLOCK pulse 2 cycles wide; FSM returns to IDLE; no repeat.
4. Auto-repeat: hold i_BTN_STEP for 60 cycles → first pulse; first repeat rises 10 low cycles after the first pulse falls; then pulses every 8 cycles (2 high, 6 low); stops ≤2 cycles after o_STEP_LEVEL falls.
5. REPEAT_ENABLE=0, hold 60 cycles → one pulse only; o_STEP_CLOCK stays 0 until release and re-press.
6. Reset mid-pulse: assert i_RESET_n=0 during PULSE → o_STEP_CLOCK=0 immediately. After release with button released, no further pulse.
